rsv_issue_pip3: RTL and testbench

Dual-queue issue buffer between decode and the 3-stage scoreboard. Accepts one decoded micro-op per cycle, steers it to the execute (pipe 0) or multiply (pipe 1) queue, and presents both queue heads with an age order flag. A head is popped when the scoreboard's pipe-select grant names that pipe.

---
 rtl/rsv_issue_pip3_pkg.sv | 39 +++
 rtl/rsv_fifo.sv | 58 +++++
 rtl/rsv_issue_pip3.sv | 129 ++++++++++++
 tb/tb_rsv_issue_pip3.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rsv_issue_pip3_pkg.sv
// Shared constants and types for the issue buffer and the scoreboard that consumes it.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package rsv_issue_pip3_pkg;

    localparam int W_PA_REG     = 5;
    localparam int W_PD_UOPS    = 6;
    localparam int W_PC_SEL_RSV = 2;
    localparam int W_PC_SEL_ODR = 2;
    localparam int S_depth      = 4;
    localparam int W_TAG        = $clog2(S_depth) + 2;

    // Pipe-select grant codes shared with the scoreboard
    localparam logic [W_PC_SEL_RSV-1:0] V_unpip = 2'b00;
    localparam logic [W_PC_SEL_RSV-1:0] V_pip0  = 2'b01;
    localparam logic [W_PC_SEL_RSV-1:0] V_pip1  = 2'b10;

    // Age-order flag codes
    localparam logic [W_PC_SEL_ODR-1:0] V_odrf0 = 2'b01;
    localparam logic [W_PC_SEL_ODR-1:0] V_odrf1 = 2'b10;

    // Bubble / empty-head micro-op code
    localparam logic [W_PD_UOPS-1:0] unused_op = '1;

    // Inclusive range of micro-ops executed by the multiply pipe
    localparam logic [W_PD_UOPS-1:0] V_mul_lo = 6'h20;
    localparam logic [W_PD_UOPS-1:0] V_mul_hi = 6'h27;

    typedef struct packed {
        logic [W_PD_UOPS-1:0] uops;
        logic [W_PA_REG-1:0]  rd;
        logic [W_TAG-1:0]     tag;
    } rsv_entry_t;

    function automatic logic is_mul_op(input logic [W_PD_UOPS-1:0] uops);
        return (uops >= V_mul_lo) && (uops <= V_mul_hi);
    endfunction

endpackage

// File: rtl/rsv_fifo.sv
// Circular FIFO of issue entries with push, pop, clear and a registered head.
// Latency: a push is visible at the head one cycle later when the FIFO was empty.
// Backpressure: push is dropped while full (pop does not free a slot the same cycle); pop on empty is ignored.
import rsv_issue_pip3_pkg::*;

module rsv_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       push,
    input  rsv_entry_t push_dat,
    input  logic       pop,
    input  logic       clear,
    output logic       full,
    output logic       empty,
    output rsv_entry_t head
);

    localparam int W_IDX = $clog2(DEPTH);
    localparam int W_PTR = W_IDX + 1;

    logic [W_PTR-1:0] wr_ptr;
    logic [W_PTR-1:0] rd_ptr;
    rsv_entry_t       mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[W_IDX] != rd_ptr[W_IDX]) &&
                     (wr_ptr[W_IDX-1:0] == rd_ptr[W_IDX-1:0]);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign head    = mem[rd_ptr[W_IDX-1:0]];

    // Pointer update: reset beats clear, clear discards same-cycle push/pop
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + W_PTR'(1);
            if (do_pop)  rd_ptr <= rd_ptr + W_PTR'(1);
        end
    end

    // Entry storage; contents are only meaningful between rd and wr pointers
    always_ff @(posedge clk) begin
        if (rstn && do_push) begin
            mem[wr_ptr[W_IDX-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/rsv_issue_pip3.sv
// Dual-queue issue buffer: steers decoded ops to execute/multiply queues, shows both heads with an age flag.
// Latency: 1 cycle push-to-head; grant sampled at an edge exposes the next entry after that edge.
// Backpressure: CDO_PC_ready = !full(target queue), bubbles always ready. Optional RSV_PERF_EN adds a stall counter.
import rsv_issue_pip3_pkg::*;

module rsv_issue_pip3 (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [W_PD_UOPS-1:0]    CDI_PD_uops,
    input  logic [W_PA_REG-1:0]     CDI_PD_rd,
    input  logic                    CDI_PC_valid,
    output logic                    CDO_PC_ready,
    output logic [W_PD_UOPS-1:0]    CDO_PD_uops0,
    output logic [W_PD_UOPS-1:0]    CDO_PD_uops1,
    output logic [W_PA_REG-1:0]     CDO_PD_rd0,
    output logic [W_PA_REG-1:0]     CDO_PD_rd1,
    output logic [W_PC_SEL_ODR-1:0] CDO_PC_odr,
    input  logic [W_PC_SEL_RSV-1:0] CDI_PC_selrsv,
    input  logic                    CFI_PC_clear
`ifdef RSV_PERF_EN
    ,
    output logic [15:0]             CDO_PD_stall_cnt
`endif
);

    logic             bubble;
    logic             to_mul;
    logic             push0;
    logic             push1;
    logic             pop0;
    logic             pop1;
    logic             full0;
    logic             full1;
    logic             empty0;
    logic             empty1;
    rsv_entry_t       head0;
    rsv_entry_t       head1;
    rsv_entry_t       in_entry;
    logic [W_TAG-1:0] tag_cnt;
    logic [W_TAG-1:0] tag_diff;

    assign bubble   = (CDI_PD_uops == unused_op);
    assign to_mul   = is_mul_op(CDI_PD_uops);
    assign in_entry = '{uops: CDI_PD_uops, rd: CDI_PD_rd, tag: tag_cnt};

    // Ready depends only on the target queue's fullness; a same-cycle pop does not help
    always_comb begin
        CDO_PC_ready = 1'b1;
        if (!bubble) begin
            CDO_PC_ready = to_mul ? !full1 : !full0;
        end
    end

    // Steering and grant decode; clear cancels any push so the tag stays put
    always_comb begin
        push0 = 1'b0;
        push1 = 1'b0;
        if (CDI_PC_valid && CDO_PC_ready && !bubble && !CFI_PC_clear) begin
            push0 = !to_mul;
            push1 = to_mul;
        end
        pop0 = (CDI_PC_selrsv == V_pip0);
        pop1 = (CDI_PC_selrsv == V_pip1);
    end

    rsv_fifo #(.DEPTH(S_depth)) u_q0 (
        .clk      (clk),
        .rstn     (rstn),
        .push     (push0),
        .push_dat (in_entry),
        .pop      (pop0),
        .clear    (CFI_PC_clear),
        .full     (full0),
        .empty    (empty0),
        .head     (head0)
    );

    rsv_fifo #(.DEPTH(S_depth)) u_q1 (
        .clk      (clk),
        .rstn     (rstn),
        .push     (push1),
        .push_dat (in_entry),
        .pop      (pop1),
        .clear    (CFI_PC_clear),
        .full     (full1),
        .empty    (empty1),
        .head     (head1)
    );

    // Age tag advances once per stored op and wraps; clear leaves it alone
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tag_cnt <= '0;
        end else if (push0 || push1) begin
            tag_cnt <= tag_cnt + W_TAG'(1);
        end
    end

    assign tag_diff = head0.tag - head1.tag;

    // Head presentation and age order, decoded purely from queue state
    always_comb begin
        CDO_PD_uops0 = empty0 ? unused_op : head0.uops;
        CDO_PD_rd0   = empty0 ? '0 : head0.rd;
        CDO_PD_uops1 = empty1 ? unused_op : head1.uops;
        CDO_PD_rd1   = empty1 ? '0 : head1.rd;
        CDO_PC_odr   = '0;
        if (!empty0 && !empty1) begin
            // Wrapped difference: pipe 0 is older when its tag lies behind pipe 1's
            CDO_PC_odr = tag_diff[W_TAG-1] ? V_odrf0 : V_odrf1;
        end else if (!empty0) begin
            CDO_PC_odr = V_odrf0;
        end else if (!empty1) begin
            CDO_PC_odr = V_odrf1;
        end
    end

`ifdef RSV_PERF_EN
    // Saturating count of cycles where decode offered an op that was refused
    always_ff @(posedge clk) begin
        if (!rstn) begin
            CDO_PD_stall_cnt <= '0;
        end else if (CDI_PC_valid && !CDO_PC_ready && (CDO_PD_stall_cnt != 16'hFFFF)) begin
            CDO_PD_stall_cnt <= CDO_PD_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rsv_issue_pip3.sv
module tb_rsv_issue_pip3;

    logic       clk = 1'b0;
    logic       rstn;
    logic [5:0] uops;
    logic [4:0] rd;
    logic       valid;
    logic       ready;
    logic [5:0] u0, u1;
    logic [4:0] r0, r1;
    logic [1:0] odr;
    logic [1:0] sel;
    logic       clr;
`ifdef RSV_PERF_EN
    logic [15:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    rsv_issue_pip3 dut (
        .clk           (clk),
        .rstn          (rstn),
        .CDI_PD_uops   (uops),
        .CDI_PD_rd     (rd),
        .CDI_PC_valid  (valid),
        .CDO_PC_ready  (ready),
        .CDO_PD_uops0  (u0),
        .CDO_PD_uops1  (u1),
        .CDO_PD_rd0    (r0),
        .CDO_PD_rd1    (r1),
        .CDO_PC_odr    (odr),
        .CDI_PC_selrsv (sel),
        .CFI_PC_clear  (clr)
`ifdef RSV_PERF_EN
        ,
        .CDO_PD_stall_cnt (stall_cnt)
`endif
    );

    typedef struct {
        logic [5:0] u;
        logic [4:0] r;
        int         seq;
    } mop_t;

    mop_t q0[$];
    mop_t q1[$];
    int   seq_n  = 0;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit mul_m(input logic [5:0] u);
        return (u >= 6'h20) && (u <= 6'h27);
    endfunction

    function automatic logic exp_ready(input logic [5:0] u);
        if (u == 6'h3F) return 1'b1;
        if (mul_m(u)) return q1.size() < 4;
        return q0.size() < 4;
    endfunction

    function automatic logic [1:0] exp_odr();
        if (q0.size() > 0 && q1.size() > 0) return (q0[0].seq < q1[0].seq) ? 2'b01 : 2'b10;
        if (q0.size() > 0) return 2'b01;
        if (q1.size() > 0) return 2'b10;
        return 2'b00;
    endfunction

    // Reference model: updates at the same edge the DUT commits
    always @(posedge clk) begin : model
        mop_t m;
        bit   acc;
        if (!rstn || clr) begin
            q0.delete();
            q1.delete();
        end else begin
            acc = valid && (uops != 6'h3F) && exp_ready(uops);
            if (sel == 2'b01 && q0.size() > 0) void'(q0.pop_front());
            if (sel == 2'b10 && q1.size() > 0) void'(q1.pop_front());
            if (acc) begin
                m.u = uops;
                m.r = rd;
                m.seq = seq_n;
                seq_n++;
                if (mul_m(uops)) q1.push_back(m);
                else q0.push_back(m);
            end
        end
    end

    // Monitor: compares presented heads, order and ready against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mon_uops0", 16'(u0), 16'(q0.size() > 0 ? q0[0].u : 6'h3F));
            chk("mon_rd0",   16'(r0), 16'(q0.size() > 0 ? q0[0].r : 5'd0));
            chk("mon_uops1", 16'(u1), 16'(q1.size() > 0 ? q1[0].u : 6'h3F));
            chk("mon_rd1",   16'(r1), 16'(q1.size() > 0 ? q1[0].r : 5'd0));
            chk("mon_odr",   16'(odr), 16'(exp_odr()));
            chk("mon_ready", 16'(ready), 16'(exp_ready(uops)));
        end
    end

    task automatic set_in(input logic v, input logic [5:0] u, input logic [4:0] r,
                          input logic [1:0] s, input logic c);
        valid = v;
        uops  = u;
        rd    = r;
        sel   = s;
        clr   = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic v, input logic [5:0] u, input logic [4:0] r,
                        input logic [1:0] s, input logic c);
        set_in(v, u, r, s, c);
        tick();
    endtask

    initial begin
        rstn = 1'b0;
        set_in(1'b0, 6'h3F, 5'd0, 2'b00, 1'b0);
        tick();
        tick();
        rstn = 1'b1;
        chk_en = 1;
        tick();

        // Reset / idle state
        chk("rst_uops0", 16'(u0), 16'h3F);
        chk("rst_uops1", 16'(u1), 16'h3F);
        chk("rst_rd0", 16'(r0), 16'h0);
        chk("rst_rd1", 16'(r1), 16'h0);
        chk("rst_odr", 16'(odr), 16'h0);
        chk("rst_ready", 16'(ready), 16'h1);

        // Grants to empty queues and the 11 code are ignored
        step(1'b0, 6'h3F, 5'd0, 2'b01, 1'b0);
        step(1'b0, 6'h3F, 5'd0, 2'b11, 1'b0);

        // One op per pipe, then grant pipe 0
        step(1'b1, 6'h01, 5'd3, 2'b00, 1'b0);
        step(1'b1, 6'h21, 5'd7, 2'b00, 1'b0);
        step(1'b0, 6'h3F, 5'd0, 2'b00, 1'b0);
        chk("two_uops0", 16'(u0), 16'h01);
        chk("two_rd0", 16'(r0), 16'd3);
        chk("two_uops1", 16'(u1), 16'h21);
        chk("two_rd1", 16'(r1), 16'd7);
        chk("two_odr", 16'(odr), 16'b01);
        step(1'b0, 6'h3F, 5'd0, 2'b01, 1'b0);
        chk("pop0_uops0", 16'(u0), 16'h3F);
        chk("pop0_odr", 16'(odr), 16'b10);
        step(1'b0, 6'h3F, 5'd0, 2'b10, 1'b0);
        chk("pop1_odr", 16'(odr), 16'b00);

        // Bubble is always ready and never stored
        set_in(1'b1, 6'h3F, 5'd9, 2'b00, 1'b0);
        #1;
        chk("bubble_ready", 16'(ready), 16'h1);
        tick();
        chk("bubble_uops0", 16'(u0), 16'h3F);

        // Fill pipe 0; the fifth op is refused while pipe 1 remains open
        for (int i = 0; i < 4; i++) step(1'b1, 6'(6'h04 + i), 5'(i + 10), 2'b00, 1'b0);
        set_in(1'b1, 6'h08, 5'd14, 2'b00, 1'b0);
        #1;
        chk("full_ready0", 16'(ready), 16'h0);
        set_in(1'b1, 6'h21, 5'd15, 2'b00, 1'b0);
        #1;
        chk("full_ready1", 16'(ready), 16'h1);
        tick();
        chk("full_uops0", 16'(u0), 16'h04);
        chk("full_odr", 16'(odr), 16'b01);
        // Full queue with a grant and a push: push refused, pop performed
        step(1'b1, 6'h09, 5'd16, 2'b01, 1'b0);
        chk("fullpop_uops0", 16'(u0), 16'h05);
        for (int i = 0; i < 3; i++) step(1'b0, 6'h3F, 5'd0, 2'b01, 1'b0);
        step(1'b0, 6'h3F, 5'd0, 2'b10, 1'b0);
        chk("drain_odr", 16'(odr), 16'b00);

        // Alternating pushes with lagged grants so the tag wraps
        for (int i = 0; i < 20; i++) begin
            logic [5:0] u;
            logic [1:0] s;
            u = (i % 2 == 0) ? 6'(6'h02 + i) : 6'(6'h20 + (i % 8));
            s = (i >= 3) ? (((i + 1) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            step(1'b1, u, 5'(i), s, 1'b0);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 6'h3F, 5'd0, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 6'h3F, 5'd0, 2'b01, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 6'h3F, 5'd0, 2'b10, 1'b0);
        chk("wrap_drained_odr", 16'(odr), 16'b00);

        // Mixed order after wrap: pipe 1 pushed first must be reported older
        step(1'b1, 6'h22, 5'd1, 2'b00, 1'b0);
        step(1'b1, 6'h03, 5'd2, 2'b00, 1'b0);
        step(1'b0, 6'h3F, 5'd0, 2'b00, 1'b0);
        chk("order_p1_older", 16'(odr), 16'b10);
        step(1'b0, 6'h3F, 5'd0, 2'b10, 1'b0);
        step(1'b0, 6'h3F, 5'd0, 2'b01, 1'b0);

        // Clear with 3 + 2 entries and a simultaneous push and grant
        for (int i = 0; i < 3; i++) step(1'b1, 6'(6'h01 + i), 5'(i), 2'b00, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, 6'(6'h24 + i), 5'(i + 20), 2'b00, 1'b0);
        step(1'b1, 6'h05, 5'd5, 2'b01, 1'b1);
        chk("clr_uops0", 16'(u0), 16'h3F);
        chk("clr_uops1", 16'(u1), 16'h3F);
        chk("clr_odr", 16'(odr), 16'b00);
        chk("clr_ready", 16'(ready), 16'h1);

        // Reset in the middle of traffic drops everything
        step(1'b1, 6'h0A, 5'd4, 2'b00, 1'b0);
        step(1'b1, 6'h26, 5'd6, 2'b00, 1'b0);
        rstn = 1'b0;
        step(1'b1, 6'h0B, 5'd8, 2'b00, 1'b0);
        rstn = 1'b1;
        step(1'b0, 6'h3F, 5'd0, 2'b00, 1'b0);
        chk("midrst_uops0", 16'(u0), 16'h3F);
        chk("midrst_uops1", 16'(u1), 16'h3F);
        chk("midrst_odr", 16'(odr), 16'b00);

`ifdef RSV_PERF_EN
        rstn = 1'b0;
        step(1'b0, 6'h3F, 5'd0, 2'b00, 1'b0);
        rstn = 1'b1;
        chk("stall_rst", stall_cnt, 16'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 6'(6'h10 + i), 5'(i), 2'b00, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 6'h14, 5'd9, 2'b00, 1'b0);
        chk("stall_six", stall_cnt, 16'd6);
        step(1'b0, 6'h3F, 5'd0, 2'b00, 1'b1);
        chk("stall_keep_on_clr", stall_cnt, 16'd6);
        rstn = 1'b0;
        step(1'b0, 6'h3F, 5'd0, 2'b00, 1'b0);
        rstn = 1'b1;
        chk("stall_rst2", stall_cnt, 16'd0);
`endif

        step(1'b0, 6'h3F, 5'd0, 2'b00, 1'b0);
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
